imm_encoder: RTL and testbench

//  Inverse of the immGen decoder: packs a signed immediate into a 32-bit RV32 instruction

---
 rtl/imm_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_imm_encoder.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Packs a signed immediate into a 32-bit RV32 instruction word for the I, S and
// B formats. This is the inverse of the immGen decoder. Every word is
// range-checked and tagged with a sequential byte address for the
// instruction-memory loader.
//
// The block is a two-stage valid/ready pipeline:
//   stage 1 : registered fmt / base / imm plus the range-error flag
//   stage 2 : registered encoded word (out_instr / out_err); out_addr is
//             the live address counter tagged onto this word
//
// A word presented with in_valid&in_ready is captured into stage 1 at that
// clock edge. It moves into stage 2 at the next edge and is then visible on
// out_valid. The pipeline can sustain one word per cycle.
//
// Parameters
//   ADDR_W     width of out_addr (byte address, wraps modulo 2^ADDR_W)
//   ERR_W      width of the saturating err_cnt
//   BASE_ADDR  out_addr value after reset/clr (multiple of 4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of address and error counters
//   in_valid   input word valid
//   in_ready   block can accept input this cycle
//   in_fmt     00 I, 01 S, 10 B, 11 reserved
//   in_base    instruction with opcode/rd/rs/funct; immediate bits ignored
//   in_imm     signed immediate (two's complement)
//   out_valid  encoded word valid
//   out_ready  consumer accepts word
//   out_instr  encoded instruction
//   out_addr   byte address of out_instr
//   out_err    immediate out of range / misaligned / reserved fmt
//   err_cnt    saturating count of delivered words with out_err=1
// -----------------------------------------------------------------------------
module imm_encoder #(
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       ERR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [31:0]       in_base,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        FMT_I   = 2'b00,
        FMT_S   = 2'b01,
        FMT_B   = 2'b10,
        FMT_RSV = 2'b11
    } fmt_e;

    // Stage 1
    logic              s1_valid_q;
    fmt_e              s1_fmt_q;
    logic [31:0]       s1_base_q;
    logic [12:0]       s1_imm_q;    // only imm[12:0] reaches any encoding
    logic              s1_err_q;

    // Stage 2
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic              out_err_q;

    // Counters
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    // Handshake / datapath nets
    fmt_e              in_fmt_e;
    logic              fits_12b;
    logic              fits_13b;
    logic              in_err;
    logic [31:0]       enc_instr;
    logic              s2_accept;
    logic              s1_advance;
    logic              in_fire;
    logic              out_fire;

    assign in_fmt_e   = fmt_e'(in_fmt);

    // Stage 2 can take a word when it is empty or is emptying this cycle.
    assign s2_accept  = !out_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_accept;
    assign in_ready   = !s1_valid_q || s2_accept;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_q && out_ready;

    // A value fits in N signed bits when bits [31:N-1] are all equal.
    assign fits_12b = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign fits_13b = (&in_imm[31:12]) || !(|in_imm[31:12]);

    // Range check runs on the raw input, so stage 1 only needs to keep the
    // low 13 immediate bits plus the resulting flag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        in_err = 1'b1;
        case (in_fmt_e)
            FMT_I, FMT_S: in_err = !fits_12b;
            FMT_B:        in_err = !fits_13b || in_imm[0];
            default:      in_err = 1'b1;
        endcase
    end

    // Encoding: immediate fields overwrite in_base. All other bits pass through.
    always_comb begin
        enc_instr = s1_base_q;
        case (s1_fmt_q)
            FMT_I: begin
                enc_instr[31:20] = s1_imm_q[11:0];
            end
            FMT_S: begin
                enc_instr[31:25] = s1_imm_q[11:5];
                enc_instr[11:7]  = s1_imm_q[4:0];
            end
            FMT_B: begin
                enc_instr[31]    = s1_imm_q[12];
                enc_instr[7]     = s1_imm_q[11];
                enc_instr[30:25] = s1_imm_q[10:5];
                enc_instr[11:8]  = s1_imm_q[4:1];
            end
            default: begin
                enc_instr = s1_base_q;
            end
        endcase
    end

    // clr takes priority over a transfer in the same cycle. out_addr is the
    // counter itself, so a word held in stage 2 is retagged with BASE_ADDR.
    always_comb begin
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            addr_d    = BASE_ADDR;
            err_cnt_d = '0;
        end else if (out_fire) begin
            addr_d = addr_q + ADDR_W'(4);
            if (out_err_q && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= FMT_I;
            s1_base_q   <= '0;
            s1_imm_q    <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            addr_q      <= BASE_ADDR;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every
            // register samples pre-edge values. For example, stage 2 reads the old
            // stage 1 contents while stage 1 loads the new input.
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_fmt_q   <= in_fmt_e;
                s1_base_q  <= in_base;
                s1_imm_q   <= in_imm[12:0];
                s1_err_q   <= in_err;
            end else if (s1_advance) begin
                s1_valid_q <= 1'b0;
            end

            // While stalled, stage 2 keeps its word so outputs stay stable.
            if (s2_accept) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_instr_q <= enc_instr;
                    out_err_q   <= s1_err_q;
                end
            end

            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_addr  = addr_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Directed bench for imm_encoder. Two instances share one set of inputs:
//   dut   - default parameters (ADDR_W=10, ERR_W=8)
//   dut_s - ADDR_W=4, ERR_W=2 for the address wrap and err_cnt saturation
//
// Inputs are driven 1 ns after the rising edge. Outputs are sampled 1 ns after
// that, so they are read away from the edge.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [1:0]  in_fmt;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [31:0] out_instr_s;
    logic [3:0]  out_addr_s;
    logic        out_err_s;
    logic [1:0]  err_cnt_s;

    int          total;
    int          bad;

    // Expected state of the default instance's counters.
    logic [9:0]  exp_addr;
    int          exp_errs;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    imm_encoder #(.ADDR_W(4), .ERR_W(2)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_fmt    (in_fmt),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_instr (out_instr_s),
        .out_addr  (out_addr_s),
        .out_err   (out_err_s),
        .err_cnt   (err_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid for at most 6 cycles.
    task automatic wait_out_valid();
        for (int i = 0; i < 6; i++) begin
            if (out_valid === 1'b1) break;
            tick();
        end
    endtask

    // Sends one word with out_ready=1, checks the delivered word, its address
    // and the counters after the transfer.
    task automatic send_one(input string name, input logic [1:0] fmt,
                            input logic [31:0] base, input logic [31:0] imm,
                            input logic [31:0] want_instr, input logic want_err);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_base   = base;
        in_imm    = imm;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready: got=%b want=1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        wait_out_valid();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: out_valid got=%b want=1", name, out_valid);
        end else begin
            total++;
            if (out_instr !== want_instr) begin
                bad++;
                $display("FAIL %s instr: got=%h want=%h", name, out_instr, want_instr);
            end
            total++;
            if (out_err !== want_err) begin
                bad++;
                $display("FAIL %s err: got=%b want=%b", name, out_err, want_err);
            end
            total++;
            if (out_addr !== exp_addr) begin
                bad++;
                $display("FAIL %s addr: got=%0d want=%0d", name, out_addr, exp_addr);
            end
        end
        tick();
        exp_addr = exp_addr + 10'd4;
        if (want_err && exp_errs < 255) exp_errs++;
        total++;
        if (err_cnt !== 8'(exp_errs)) begin
            bad++;
            $display("FAIL %s err_cnt: got=%0d want=%0d", name, err_cnt, exp_errs);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got=%b want=1", in_ready); end
        total++;
        if (out_instr !== 32'h0) begin bad++; $display("FAIL reset out_instr: got=%h want=0", out_instr); end
        total++;
        if (out_err !== 1'b0) begin bad++; $display("FAIL reset out_err: got=%b want=0", out_err); end
        total++;
        if (out_addr !== 10'd0) begin bad++; $display("FAIL reset out_addr: got=%0d want=0", out_addr); end
        total++;
        if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset err_cnt: got=%0d want=0", err_cnt); end
        #4;
        rst_n = 1'b1;
        tick();
        exp_addr = 10'd0;
        exp_errs = 0;
    endtask

    task automatic test_i_type();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_fmt    = 2'b00;
        in_base   = 32'h0000_0093;
        in_imm    = 32'hFFFF_FFFF;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL i_type in_ready: got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL i_type early out_valid: got=%b want=0", out_valid); end
        tick();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL i_type out_valid: got=%b want=1", out_valid); end
        total++;
        if (out_instr !== 32'hFFF0_0093) begin bad++; $display("FAIL i_type instr: got=%h want=fff00093", out_instr); end
        total++;
        if (out_err !== 1'b0) begin bad++; $display("FAIL i_type err: got=%b want=0", out_err); end
        total++;
        if (out_addr !== 10'd0) begin bad++; $display("FAIL i_type addr: got=%0d want=0", out_addr); end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL i_type drained out_valid: got=%b want=0", out_valid); end
        total++;
        if (out_addr !== 10'd4) begin bad++; $display("FAIL i_type next addr: got=%0d want=4", out_addr); end
        exp_addr = 10'd4;
        // Immediate bit positions of in_base must be overwritten.
        send_one("i_base_imm_bits", 2'b00, 32'hFFF0_0093, 32'h0000_0123, 32'h1230_0093, 1'b0);
    endtask

    task automatic test_s_b();
        send_one("s_type",    2'b01, 32'h0000_2023, 32'h0000_07FF, 32'h7E00_2FA3, 1'b0);
        send_one("b_type",    2'b10, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send_one("b_odd_err", 2'b10, 32'h0000_0063, 32'h0000_0003, 32'h0000_0163, 1'b1);
        total++;
        if (err_cnt !== 8'd1) begin bad++; $display("FAIL b_odd err_cnt: got=%0d want=1", err_cnt); end
    endtask

    task automatic test_range_edges();
        send_one("i_2048",    2'b00, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1);
        send_one("i_m2048",   2'b00, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
        send_one("s_m2049",   2'b01, 32'h0000_2023, 32'hFFFF_F7FF, 32'h7E00_2FA3, 1'b1);
        send_one("b_4094",    2'b10, 32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0);
        send_one("b_m4096",   2'b10, 32'h0000_0063, 32'hFFFF_F000, 32'h8000_0063, 1'b0);
        send_one("b_4096",    2'b10, 32'h0000_0063, 32'h0000_1000, 32'h8000_0063, 1'b1);
        send_one("fmt_rsv",   2'b11, 32'hDEAD_BEEF, 32'h0000_0005, 32'hDEAD_BEEF, 1'b1);
    endtask

    task automatic test_clr();
        // Word held in stage 2 is retagged by clr.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 2'b10;
        in_base   = 32'h0000_0063;
        in_imm    = 32'h0000_0003;
        #1;
        tick();
        in_valid = 1'b0;
        wait_out_valid();
        total++;
        if (out_addr !== exp_addr) begin bad++; $display("FAIL clr_hold pre addr: got=%0d want=%0d", out_addr, exp_addr); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_hold out_valid: got=%b want=1", out_valid); end
        total++;
        if (out_instr !== 32'h0000_0163) begin bad++; $display("FAIL clr_hold instr: got=%h want=00000163", out_instr); end
        total++;
        if (out_addr !== 10'd0) begin bad++; $display("FAIL clr_hold retag addr: got=%0d want=0", out_addr); end
        total++;
        if (err_cnt !== 8'd0) begin bad++; $display("FAIL clr_hold err_cnt: got=%0d want=0", err_cnt); end
        out_ready = 1'b1;
        tick();
        total++;
        if (err_cnt !== 8'd1) begin bad++; $display("FAIL clr_hold delivered err_cnt: got=%0d want=1", err_cnt); end
        total++;
        if (out_addr !== 10'd4) begin bad++; $display("FAIL clr_hold delivered addr: got=%0d want=4", out_addr); end

        // clr together with an error transfer: clr wins.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        wait_out_valid();
        total++;
        if (out_err !== 1'b1) begin bad++; $display("FAIL clr_xfer pre err: got=%b want=1", out_err); end
        clr       = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_xfer out_valid: got=%b want=0", out_valid); end
        total++;
        if (err_cnt !== 8'd0) begin bad++; $display("FAIL clr_xfer err_cnt: got=%0d want=0", err_cnt); end
        total++;
        if (out_addr !== 10'd0) begin bad++; $display("FAIL clr_xfer out_addr: got=%0d want=0", out_addr); end
        total++;
        if (out_addr_s !== 4'd0) begin bad++; $display("FAIL clr_xfer small out_addr: got=%0d want=0", out_addr_s); end
        exp_addr = 10'd0;
        exp_errs = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] got_instr [4];
        logic [9:0]  got_addr  [4];
        int          n_in;
        int          n_out;
        int          cycles;

        out_ready = 1'b0;
        in_fmt    = 2'b00;
        in_base   = 32'h0000_0013;
        in_valid  = 1'b1;
        in_imm    = 32'd1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp accept0 in_ready: got=%b want=1", in_ready); end
        tick();
        in_imm = 32'd2;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp accept1 in_ready: got=%b want=1", in_ready); end
        tick();
        in_imm = 32'd3;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp full in_ready: got=%b want=0", in_ready); end
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp stall in_ready: got=%b want=0", in_ready); end
        total++;
        if (out_valid !== 1'b1 || out_instr !== 32'h0010_0013) begin
            bad++;
            $display("FAIL bp stable word: got=%b/%h want=1/00100013", out_valid, out_instr);
        end
        total++;
        if (out_addr !== 10'd0) begin bad++; $display("FAIL bp stable addr: got=%0d want=0", out_addr); end

        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp release in_ready: got=%b want=1", in_ready); end

        n_in   = 2;
        n_out  = 0;
        cycles = 0;
        while (n_out < 4 && cycles < 20) begin
            in_valid = (n_in < 4);
            in_imm   = 32'(n_in + 1);
            #1;
            if (out_valid === 1'b1) begin
                got_instr[n_out] = out_instr;
                got_addr[n_out]  = out_addr;
                n_out++;
            end
            if (in_valid && in_ready === 1'b1) n_in++;
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        total++;
        if (n_out != 4) begin
            bad++;
            $display("FAIL bp count: got=%0d want=4", n_out);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got_instr[k] !== (32'(k + 1) << 20 | 32'h13) || got_addr[k] !== 10'(4 * k)) begin
                    bad++;
                    $display("FAIL bp word%0d: got=%h@%0d want=%h@%0d", k, got_instr[k], got_addr[k],
                             32'(k + 1) << 20 | 32'h13, 4 * k);
                end
            end
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp duplicate: out_valid got=%b want=0", out_valid); end
        exp_addr = 10'd16;
    endtask

    task automatic test_wrap_saturate();
        logic [3:0] got_addr [5];
        int         n_in;
        int         n_out;
        int         cycles;

        out_ready = 1'b1;
        in_fmt    = 2'b11;
        in_imm    = 32'd0;
        n_in      = 0;
        n_out     = 0;
        cycles    = 0;
        while (n_out < 5 && cycles < 20) begin
            in_valid = (n_in < 5);
            in_base  = 32'(32'h100 + n_in);
            #1;
            if (out_valid_s === 1'b1) begin
                got_addr[n_out] = out_addr_s;
                n_out++;
            end
            if (in_valid && in_ready === 1'b1) n_in++;
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        total++;
        if (n_out != 5) begin
            bad++;
            $display("FAIL wrap count: got=%0d want=5", n_out);
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (got_addr[k] !== 4'((4 * k) % 16)) begin
                    bad++;
                    $display("FAIL wrap addr%0d: got=%0d want=%0d", k, got_addr[k], (4 * k) % 16);
                end
            end
        end
        // Two cycles of fill, then one word per cycle.
        total++;
        if (cycles > 7) begin bad++; $display("FAIL wrap throughput cycles: got=%0d want<=7", cycles); end
        total++;
        if (err_cnt_s !== 2'd3) begin bad++; $display("FAIL sat err_cnt_s: got=%0d want=3", err_cnt_s); end
        total++;
        if (out_addr_s !== 4'd4) begin bad++; $display("FAIL wrap final addr_s: got=%0d want=4", out_addr_s); end
        total++;
        if (err_cnt !== 8'd5) begin bad++; $display("FAIL wrap big err_cnt: got=%0d want=5", err_cnt); end
        total++;
        if (out_addr !== 10'd36) begin bad++; $display("FAIL wrap big addr: got=%0d want=36", out_addr); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 2'b11;
        in_base   = 32'h0000_0ABC;
        #1;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid pre out_valid: got=%b want=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid out_valid: got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid in_ready: got=%b want=1", in_ready); end
        total++;
        if (out_addr !== 10'd0 || out_addr_s !== 4'd0) begin
            bad++;
            $display("FAIL rst_mid out_addr: got=%0d/%0d want=0/0", out_addr, out_addr_s);
        end
        total++;
        if (err_cnt !== 8'd0 || err_cnt_s !== 2'd0) begin
            bad++;
            $display("FAIL rst_mid err_cnt: got=%0d/%0d want=0/0", err_cnt, err_cnt_s);
        end
        total++;
        if (out_instr !== 32'h0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid word: got=%h/%b want=0/0", out_instr, out_err);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid discarded: out_valid got=%b want=0", out_valid); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_addr  = 10'd0;
        exp_errs  = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = 2'b00;
        in_base   = 32'h0;
        in_imm    = 32'h0;
        out_ready = 1'b0;

        test_reset();
        test_i_type();
        test_s_b();
        test_range_edges();
        test_clr();
        test_backpressure();
        test_wrap_saturate();
        test_reset_midstream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
